bcd_number_entry: RTL and testbench

//  Keypad number-entry block: accepts decimal digits one at a time, MSD first,
//  and assembles an N-digit value. Supports clear, backspace and a commit

---
 rtl/bcd_entry_pkg.sv | 21 ++
 rtl/bcd_to_bin.sv | 25 ++
 rtl/bcd_number_entry.sv | 127 ++++++++++++
 tb/tb_bcd_number_entry.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_entry_pkg.sv
// Shared types and helpers for the keypad BCD number-entry block.
package bcd_entry_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        ENTRY,
        FULL
    } entry_state_e;

    localparam logic [3:0] DIGIT_MAX = 4'd9;

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_to_bin.sv
// Combinational BCD-to-binary converter: sum of digit[i] * 10**i.
module bcd_to_bin
    import bcd_entry_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int BIN_W      = 11
) (
    input  logic [4*NUM_DIGITS-1:0] bcd,
    output logic [BIN_W-1:0]        bin
);

    logic [BIN_W-1:0] acc [0:NUM_DIGITS];

    assign acc[0] = '0;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            localparam logic [BIN_W-1:0] WEIGHT = BIN_W'(pow10(gi));
            assign acc[gi+1] = acc[gi] + BIN_W'(bcd[4*gi +: 4]) * WEIGHT;
        end
    endgenerate

    assign bin = acc[NUM_DIGITS];

endmodule

// File: rtl/bcd_number_entry.sv
// Keypad number entry: shifts decimal digits in MSD-first, supports clear,
// backspace and a range-checked commit to a binary value.
module bcd_number_entry
    import bcd_entry_pkg::*;
#(
    parameter  int NUM_DIGITS = 2,
    parameter  int MAX_VALUE  = 99,
    parameter  bit SATURATE   = 1'b0,
    localparam int VALUE_W    = $clog2(MAX_VALUE + 1),
    localparam int BCD_W      = 4 * NUM_DIGITS
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               digit_valid,
    input  logic [3:0]         digit,
    input  logic               clear,
    input  logic               backspace,
    input  logic               commit,
    output logic [BCD_W-1:0]   bcd,
    output logic [2:0]         count,
    output logic [VALUE_W-1:0] value,
    output logic               commit_done,
    output logic               err
);

    // Wide enough for any held entry, so over-range never wraps even when
    // MAX_VALUE is much smaller than the digit capacity.
    localparam int BIN_W_MIN  = VALUE_W + 4;
    localparam int BIN_W_FULL = $clog2(pow10(NUM_DIGITS));
    localparam int BIN_W      = (BIN_W_FULL > BIN_W_MIN) ? BIN_W_FULL : BIN_W_MIN;

    localparam logic [2:0]         COUNT_FULL = 3'(NUM_DIGITS);
    localparam logic [BIN_W-1:0]   MAX_BIN    = BIN_W'(MAX_VALUE);
    localparam logic [VALUE_W-1:0] MAX_VAL    = VALUE_W'(MAX_VALUE);

    entry_state_e       state_q, state_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [2:0]         count_q, count_d;
    logic [VALUE_W-1:0] value_q, value_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [BIN_W-1:0]   bin;

    bcd_to_bin #(
        .NUM_DIGITS (NUM_DIGITS),
        .BIN_W      (BIN_W)
    ) u_bcd_to_bin (
        .bcd (bcd_q),
        .bin (bin)
    );

    always_comb begin
        bcd_d   = bcd_q;
        count_d = count_q;
        value_d = value_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (clear) begin
            bcd_d   = '0;
            count_d = '0;
        end else if (commit) begin
            if (state_q == EMPTY) begin
                err_d = 1'b1;
            end else if (bin <= MAX_BIN) begin
                value_d = bin[VALUE_W-1:0];
                done_d  = 1'b1;
                bcd_d   = '0;
                count_d = '0;
            end else if (SATURATE) begin
                value_d = MAX_VAL;
                done_d  = 1'b1;
                bcd_d   = '0;
                count_d = '0;
            end else begin
                err_d = 1'b1;
            end
        end else if (backspace) begin
            if (state_q == EMPTY) begin
                err_d = 1'b1;
            end else begin
                bcd_d   = bcd_q >> 4;
                count_d = count_q - 3'd1;
            end
        end else if (digit_valid) begin
            if ((digit > DIGIT_MAX) || (state_q == FULL)) begin
                err_d = 1'b1;
            end else begin
                bcd_d   = (bcd_q << 4) | BCD_W'(digit);
                count_d = count_q + 3'd1;
            end
        end

        if (count_d == 3'd0) begin
            state_d = EMPTY;
        end else if (count_d == COUNT_FULL) begin
            state_d = FULL;
        end else begin
            state_d = ENTRY;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= EMPTY;
            bcd_q   <= '0;
            count_q <= '0;
            value_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            count_q <= count_d;
            value_q <= value_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bcd         = bcd_q;
    assign count       = count_q;
    assign value       = value_q;
    assign commit_done = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_bcd_number_entry.sv
// Bench for bcd_number_entry: three configurations share one stimulus stream
// and are checked against a digit-list reference model.
module tb_bcd_number_entry;
    import bcd_entry_pkg::*;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       digit_valid = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       clear = 1'b0;
    logic       backspace = 1'b0;
    logic       commit = 1'b0;

    logic [7:0]  bcd0, bcd1;
    logic [11:0] bcd2;
    logic [2:0]  cnt0, cnt1, cnt2;
    logic [5:0]  val0, val1;
    logic [9:0]  val2;
    logic        done0, done1, done2;
    logic        err0, err1, err2;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    // Reference model: digits held MSD first, plus last committed value.
    int m_dig [NI][8];
    int m_cnt [NI];
    int m_val [NI];
    int m_done[NI];
    int m_err [NI];

    always #10 clk = ~clk;

    bcd_number_entry #(.NUM_DIGITS(2), .MAX_VALUE(50), .SATURATE(1'b0)) u_rej (
        .CLOCK_50(clk), .reset(reset), .digit_valid(digit_valid), .digit(digit),
        .clear(clear), .backspace(backspace), .commit(commit),
        .bcd(bcd0), .count(cnt0), .value(val0), .commit_done(done0), .err(err0));

    bcd_number_entry #(.NUM_DIGITS(2), .MAX_VALUE(50), .SATURATE(1'b1)) u_sat (
        .CLOCK_50(clk), .reset(reset), .digit_valid(digit_valid), .digit(digit),
        .clear(clear), .backspace(backspace), .commit(commit),
        .bcd(bcd1), .count(cnt1), .value(val1), .commit_done(done1), .err(err1));

    bcd_number_entry #(.NUM_DIGITS(3), .MAX_VALUE(999), .SATURATE(1'b0)) u_n3 (
        .CLOCK_50(clk), .reset(reset), .digit_valid(digit_valid), .digit(digit),
        .clear(clear), .backspace(backspace), .commit(commit),
        .bcd(bcd2), .count(cnt2), .value(val2), .commit_done(done2), .err(err2));

    function automatic int p_n(input int k);
        return (k == 2) ? 3 : 2;
    endfunction

    function automatic int p_max(input int k);
        return (k == 2) ? 999 : 50;
    endfunction

    function automatic bit p_sat(input int k);
        return (k == 1);
    endfunction

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int exp_bcd(input int k);
        int e = 0;
        for (int i = 0; i < m_cnt[k]; i++) e = e * 16 + m_dig[k][i];
        return e;
    endfunction

    function automatic int exp_bin(input int k);
        int e = 0;
        for (int i = 0; i < m_cnt[k]; i++) e = e * 10 + m_dig[k][i];
        return e;
    endfunction

    task automatic model_step(input int k, input bit rst, input bit clr, input bit cmt,
                              input bit bs, input bit dv, input int dg);
        int b;
        m_done[k] = 0;
        m_err[k]  = 0;
        if (rst) begin
            m_cnt[k] = 0;
            m_val[k] = 0;
        end else if (clr) begin
            m_cnt[k] = 0;
        end else if (cmt) begin
            b = exp_bin(k);
            if (m_cnt[k] == 0) begin
                m_err[k] = 1;
            end else if (b <= p_max(k)) begin
                m_val[k] = b; m_done[k] = 1; m_cnt[k] = 0;
            end else if (p_sat(k)) begin
                m_val[k] = p_max(k); m_done[k] = 1; m_cnt[k] = 0;
            end else begin
                m_err[k] = 1;
            end
        end else if (bs) begin
            if (m_cnt[k] == 0) m_err[k] = 1;
            else m_cnt[k]--;
        end else if (dv) begin
            if (dg > 9 || m_cnt[k] == p_n(k)) begin
                m_err[k] = 1;
            end else begin
                m_dig[k][m_cnt[k]] = dg;
                m_cnt[k]++;
            end
        end
    endtask

    task automatic check_inst(input int k, input int unsigned b, input int unsigned c,
                              input int unsigned v, input int unsigned d, input int unsigned e);
        check($sformatf("i%0d bcd", k),         b, exp_bcd(k));
        check($sformatf("i%0d count", k),       c, m_cnt[k]);
        check($sformatf("i%0d value", k),       v, m_val[k]);
        check($sformatf("i%0d commit_done", k), d, m_done[k]);
        check($sformatf("i%0d err", k),         e, m_err[k]);
    endtask

    // One transaction: apply strobes for one edge, then compare all instances.
    task automatic step(input bit rst, input bit clr, input bit cmt, input bit bs,
                        input bit dv, input int dg);
        reset = rst; clear = clr; commit = cmt; backspace = bs;
        digit_valid = dv; digit = 4'(dg);
        @(posedge clk);
        cyc++;
        for (int k = 0; k < NI; k++) model_step(k, rst, clr, cmt, bs, dv, dg);
        #1;
        $display("[TB] cyc %0d rst=%0b clr=%0b cmt=%0b bs=%0b dv=%0b dg=%0d | bcd=%h/%h/%h cnt=%0d/%0d/%0d val=%0d/%0d/%0d done=%b%b%b err=%b%b%b",
                 cyc, rst, clr, cmt, bs, dv, dg, bcd0, bcd1, bcd2, cnt0, cnt1, cnt2,
                 val0, val1, val2, done0, done1, done2, err0, err1, err2);
        check_inst(0, bcd0, cnt0, val0, done0, err0);
        check_inst(1, bcd1, cnt1, val1, done1, err1);
        check_inst(2, bcd2, cnt2, val2, done2, err2);
        reset = 1'b0; clear = 1'b0; commit = 1'b0; backspace = 1'b0; digit_valid = 1'b0;
    endtask

    task automatic key(input int dg);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, dg);
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            m_cnt[k] = 0; m_val[k] = 0; m_done[k] = 0; m_err[k] = 0;
        end
        #5;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // 4,2 then commit
        key(4); key(2);
        check("bcd 0x42", bcd0, 32'h42);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        check("value 42", val0, 42);
        check("commit_done pulse", done0, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("commit_done drops", done0, 0);

        // 7,3,5: overflow on 2-digit instances, fills the 3-digit one
        key(7); key(3); key(5);
        check("full err", err0, 1);
        check("full bcd", bcd0, 32'h73);
        check("n3 bcd", bcd2, 32'h735);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);

        // 9,9 over-range commit: rejected vs saturated
        key(9); key(9);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        check("reject err", err0, 1);
        check("reject bcd", bcd0, 32'h99);
        check("sat value", val1, 50);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);

        // backspace
        key(1); key(8);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        check("bs bcd", bcd0, 32'h01);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        check("bs empty err", err0, 1);

        // clear beats commit and digit
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5);
        key(12);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        key(3);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("reset value", val2, 0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 65, int'($urandom_range(0, 12)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
